// File: rtl/stim_pkg.sv
// Shared types and elaboration-time helpers for the NCO stimulus generator.
// The sine table is computed from these functions, so the RTL does not depend on a ROM file.
package stim_pkg;

  typedef enum logic [1:0] {
    MODE_SINE    = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_SAW     = 2'd2,
    MODE_IMPULSE = 2'd3
  } mode_e;

  localparam real PI = 3.14159265358979323846;

  // Full-scale peak that is symmetric about zero, so negation can never overflow.
  function automatic int amplitude(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Quarter-wave entry k of n, sampled at bin centres so the four quadrants mirror exactly.
  function automatic int quarter_sine(input int k, input int n, input int w);
    real x;
    x = real'(amplitude(w)) * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(n));
    return int'(x);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Synchronous-read quarter-wave sine table holding unsigned magnitudes.
// The sign and the mirrored index are applied outside the table.
module quarter_sine_rom
  import stim_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-2:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int EW    = DATA_WIDTH - 1;

  logic [EW-1:0] lut [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    assign lut[k] = EW'(quarter_sine(k, DEPTH, DATA_WIDTH));
  end

  // NOTE: the table is constant and is never reset; only the read register is, so a reset flushes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      // NOTE: registered state is always written with <= so every flop samples pre-edge values.
      q <= lut[addr];
    end
  end

endmodule

// File: rtl/nco_stim_gen.sv
// Multi-channel NCO stimulus source: sample-rate divider, per-channel phase accumulators,
// and a 2-stage pipeline (LUT read / waveform select) with matching valid and wrap pulses.
module nco_stim_gen
  import stim_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = 9,
  parameter int CHANNELS       = 2,
  parameter int DIV_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en,
  input  logic [1:0]                      mode,
  input  logic [DIV_WIDTH-1:0]            sample_div,
  input  logic                            phase_clr,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] freq_word,
  input  logic [CHANNELS*PHASE_WIDTH-1:0] phase_offset,
  output logic [CHANNELS*DATA_WIDTH-1:0]  data_out,
  output logic                            data_valid,
  output logic [CHANNELS-1:0]             wrap
);

  localparam int PW = PHASE_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int AW = LUT_ADDR_WIDTH;
  localparam logic signed [DW-1:0] AMP = DW'(amplitude(DW));

  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [DIV_WIDTH-1:0] div_limit;
  logic                 strobe;
  logic                 first_pend;
  logic                 s1_valid;
  logic                 s1_first;
  mode_e                s1_mode;

  // The period length is taken from sample_div at count 0 and held for the rest of that period.
  assign div_limit = (div_cnt == '0) ? sample_div : div_lat;
  assign strobe    = en && !phase_clr && (div_cnt == div_limit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      div_lat    <= '0;
      first_pend <= 1'b1;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_mode    <= MODE_SINE;
      data_valid <= 1'b0;
    end else begin
      if (phase_clr) begin
        div_cnt <= '0;
      end else if (en) begin
        if (div_cnt == '0) div_lat <= sample_div;
        div_cnt <= (div_cnt == div_limit) ? '0 : div_cnt + 1'b1;
      end

      if (phase_clr)   first_pend <= 1'b1;
      else if (strobe) first_pend <= 1'b0;

      if (en) begin
        s1_valid   <= strobe;
        s1_first   <= first_pend;
        s1_mode    <= mode_e'(mode);
        data_valid <= s1_valid;
      end else begin
        data_valid <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PW-1:0]        acc;
    logic [PW-1:0]        sum;
    logic                 carry;
    logic                 wrap_pend;
    logic [1:0]           quad;
    logic [AW-1:0]        idx;
    logic [1:0]           s1_quad;
    logic [DW-1:0]        s1_top;
    logic                 s1_wrap;
    logic [DW-2:0]        rom_q;
    logic signed [DW-1:0] sine_v;
    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] out_q;
    logic                 wrap_q;

    assign {carry, sum} = {1'b0, acc} + {1'b0, freq_word[c*PW +: PW]};
    assign quad = acc[PW-1 -: 2];
    // Odd quadrants run the quarter wave backwards.
    assign idx  = quad[0] ? ~acc[PW-3 -: AW] : acc[PW-3 -: AW];

    quarter_sine_rom #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
    ) u_rom (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .addr    (idx),
      .q       (rom_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc       <= '0;
        wrap_pend <= 1'b0;
        s1_quad   <= '0;
        s1_top    <= '0;
        s1_wrap   <= 1'b0;
        out_q     <= '0;
        wrap_q    <= 1'b0;
      end else begin
        if (phase_clr) begin
          acc       <= phase_offset[c*PW +: PW];
          wrap_pend <= 1'b0;
        end else if (strobe) begin
          acc       <= sum;
          wrap_pend <= carry;
        end

        if (en) begin
          s1_quad <= quad;
          s1_top  <= acc[PW-1 -: DW];
          s1_wrap <= wrap_pend;
          if (s1_valid) out_q <= sample;
          wrap_q  <= s1_valid && s1_wrap;
        end else begin
          wrap_q  <= 1'b0;
        end
      end
    end

    assign sine_v = s1_quad[1] ? -$signed({1'b0, rom_q}) : $signed({1'b0, rom_q});

    // NOTE: a default assignment up front keeps this combinational block from inferring a latch.
    always_comb begin
      sample = '0;
      unique case (s1_mode)
        MODE_SINE:    sample = sine_v;
        MODE_SQUARE:  sample = s1_top[DW-1] ? -AMP : AMP;
        MODE_SAW:     sample = {~s1_top[DW-1], s1_top[DW-2:0]};
        MODE_IMPULSE: sample = (s1_wrap || s1_first) ? AMP : '0;
        default:      sample = '0;
      endcase
    end

    assign data_out[c*DW +: DW] = out_q;
    assign wrap[c]              = wrap_q;
  end

endmodule

// File: tb/tb_nco_stim_gen.sv
// Directed bench for nco_stim_gen: one task per feature, hand-computed expected samples.
module tb_nco_stim_gen;

  localparam int DW = 16;
  localparam int PW = 24;
  localparam int CH = 2;
  localparam int DV = 16;
  localparam int FW64 = 262144;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [DV-1:0]   sample_div = '0;
  logic            phase_clr = 1'b0;
  logic [CH*PW-1:0] freq_word = '0;
  logic [CH*PW-1:0] phase_offset = '0;
  logic [CH*DW-1:0] data_out;
  logic            data_valid;
  logic [CH-1:0]   wrap;

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] s0 [128];
  logic signed [DW-1:0] s1 [128];
  logic [CH-1:0]        sw [128];
  int                   sc [128];
  int                   ncap;

  always #5 clk = ~clk;

  nco_stim_gen #(
    .DATA_WIDTH     (DW),
    .PHASE_WIDTH    (PW),
    .LUT_ADDR_WIDTH (9),
    .CHANNELS       (CH),
    .DIV_WIDTH      (DV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .mode         (mode),
    .sample_div   (sample_div),
    .phase_clr    (phase_clr),
    .freq_word    (freq_word),
    .phase_offset (phase_offset),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .wrap         (wrap)
  );

  task automatic set_fw(input int f0, input int f1);
    freq_word = {PW'(f1), PW'(f0)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic capture(input int n, input int budget);
    int cyc = 0;
    ncap = 0;
    while (ncap < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (data_valid) begin
        s0[ncap] = data_out[DW-1:0];
        s1[ncap] = data_out[2*DW-1:DW];
        sw[ncap] = wrap;
        sc[ncap] = cyc;
        ncap++;
      end
    end
    checks++;
    if (ncap != n) begin
      errors++;
      $display("FAIL capture_timeout: got %0d samples, required %0d", ncap, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", data_out); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
    checks++;
    if (wrap !== '0) begin errors++; $display("FAIL reset_wrap: got %b, required 0", wrap); end
  endtask

  task automatic test_sine_basic();
    int bad_gap = 0;
    int bad_wrap = 0;
    mode = 2'd0; sample_div = '0; set_fw(FW64, FW64); phase_offset = '0; en = 1'b1;
    do_reset();
    capture(65, 200);
    checks++;
    if (sc[0] !== 2) begin errors++; $display("FAIL sine_latency: first valid at cycle %0d, required 2", sc[0]); end
    checks++;
    if (int'(s0[0]) !== 50) begin errors++; $display("FAIL sine_s0: got %0d, required 50", s0[0]); end
    checks++;
    if (int'(s0[16]) !== 32767) begin errors++; $display("FAIL sine_s16: got %0d, required 32767", s0[16]); end
    checks++;
    if (int'(s0[32]) !== -50) begin errors++; $display("FAIL sine_s32: got %0d, required -50", s0[32]); end
    checks++;
    if (int'(s0[48]) !== -32767) begin errors++; $display("FAIL sine_s48: got %0d, required -32767", s0[48]); end
    for (int k = 1; k < 65; k++) if (sc[k] - sc[k-1] != 1) bad_gap++;
    for (int k = 0; k < 65; k++) if (sw[k][0] !== (k == 64)) bad_wrap++;
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL sine_every_clk: %0d gaps, required 0", bad_gap); end
    checks++;
    if (bad_wrap != 0) begin errors++; $display("FAIL sine_wrap: %0d wrong wrap flags, required 0", bad_wrap); end
  endtask

  task automatic test_divider();
    int bad_gap = 0;
    sample_div = 16'd3;
    do_reset();
    capture(17, 200);
    checks++;
    if (sc[0] !== 5) begin errors++; $display("FAIL div_latency: first valid at cycle %0d, required 5", sc[0]); end
    for (int k = 1; k < 17; k++) if (sc[k] - sc[k-1] != 4) bad_gap++;
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL div_spacing: %0d bad gaps, required 0", bad_gap); end
    checks++;
    if (int'(s0[0]) !== 50 || int'(s0[16]) !== 32767)
      begin errors++; $display("FAIL div_samples: got %0d/%0d, required 50/32767", s0[0], s0[16]); end
  endtask

  task automatic test_modes();
    int bad;
    int exp;
    sample_div = '0;
    mode = 2'd1;
    do_reset();
    capture(64, 200);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      exp = (k < 32) ? 32767 : -32767;
      if (int'(s0[k]) !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL square: %0d wrong samples, required 0", bad); end

    mode = 2'd2;
    do_reset();
    capture(64, 200);
    bad = 0;
    for (int k = 0; k < 64; k++) if (int'(s0[k]) !== -32768 + 1024 * k) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL saw: %0d wrong samples (s63=%0d, required 31744)", bad, s0[63]); end

    mode = 2'd3;
    do_reset();
    capture(65, 200);
    bad = 0;
    for (int k = 0; k < 65; k++) begin
      exp = (k == 0 || k == 64) ? 32767 : 0;
      if (int'(s0[k]) !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL impulse: %0d wrong samples, required 0", bad); end
    mode = 2'd0;
  endtask

  task automatic test_two_channel();
    int bad0 = 0;
    int bad1 = 0;
    set_fw(FW64, 2 * FW64);
    phase_offset = {PW'(24'h400000), PW'(0)};
    en = 1'b0;
    do_reset();
    phase_clr = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0;
    en = 1'b1;
    capture(64, 200);
    checks++;
    if (int'(s1[0]) !== 32767) begin errors++; $display("FAIL ch1_s0: got %0d, required 32767", s1[0]); end
    checks++;
    if (int'(s1[8]) !== -50) begin errors++; $display("FAIL ch1_s8: got %0d, required -50", s1[8]); end
    checks++;
    if (int'(s0[0]) !== 50) begin errors++; $display("FAIL ch0_s0: got %0d, required 50", s0[0]); end
    for (int k = 0; k < 64; k++) begin
      if (sw[k][0] !== 1'b0) bad0++;
      if (sw[k][1] !== (k == 24 || k == 56)) bad1++;
    end
    checks++;
    if (bad0 != 0 || bad1 != 0)
      begin errors++; $display("FAIL two_ch_wrap: ch0 %0d / ch1 %0d wrong flags, required 0/0", bad0, bad1); end
  endtask

  task automatic test_clear_priority();
    int bad_valid = 0;
    logic exp_v;
    set_fw(FW64, FW64);
    phase_offset = {PW'(0), PW'(24'h800000)};
    sample_div = 16'd3;
    en = 1'b1;
    do_reset();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      exp_v = (cyc == 5 || cyc == 13 || cyc == 17 || cyc == 21);
      if (data_valid !== exp_v) bad_valid++;
      if (cyc == 5) begin
        checks++;
        if (int'($signed(data_out[DW-1:0])) !== 50)
          begin errors++; $display("FAIL clr_pre: got %0d, required 50", $signed(data_out[DW-1:0])); end
      end
      if (cyc == 13) begin
        checks++;
        if (int'($signed(data_out[DW-1:0])) !== -50 || int'($signed(data_out[2*DW-1:DW])) !== 50)
          begin errors++; $display("FAIL clr_offset: got %0d/%0d, required -50/50",
                                   $signed(data_out[DW-1:0]), $signed(data_out[2*DW-1:DW])); end
      end
      phase_clr = (cyc == 7);
    end
    phase_clr = 1'b0;
    checks++;
    if (bad_valid != 0) begin errors++; $display("FAIL clr_valid_timing: %0d wrong cycles, required 0", bad_valid); end
    sample_div = '0;
    phase_offset = '0;
  endtask

  task automatic test_enable_hold();
    int bad_hold = 0;
    set_fw(FW64, FW64);
    en = 1'b1;
    do_reset();
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (cyc == 18) begin
        checks++;
        if (data_valid !== 1'b1 || int'($signed(data_out[DW-1:0])) !== 32767)
          begin errors++; $display("FAIL hold_pre: valid %b data %0d, required 1/32767", data_valid, $signed(data_out[DW-1:0])); end
      end
      if (cyc >= 19 && cyc <= 28)
        if (data_valid !== 1'b0 || wrap !== '0 || int'($signed(data_out[DW-1:0])) !== 32767) bad_hold++;
      if (cyc == 29) begin
        checks++;
        if (data_valid !== 1'b1) begin errors++; $display("FAIL hold_resume: valid %b, required 1", data_valid); end
      end
      if (cyc == 44) begin
        checks++;
        if (data_valid !== 1'b1 || int'($signed(data_out[DW-1:0])) !== -50)
          begin errors++; $display("FAIL hold_s32: valid %b data %0d, required 1/-50", data_valid, $signed(data_out[DW-1:0])); end
      end
      en = !(cyc >= 18 && cyc < 28);
    end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL hold_frozen: %0d bad cycles, required 0", bad_hold); end
  endtask

  task automatic test_reset_midstream();
    set_fw(FW64, FW64);
    en = 1'b1;
    do_reset();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || data_valid !== 1'b0 || wrap !== '0)
      begin errors++; $display("FAIL async_reset: data %h valid %b wrap %b, required 0", data_out, data_valid, wrap); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL stray_valid: got %b, required 0", data_valid); end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || int'($signed(data_out[DW-1:0])) !== 50)
      begin errors++; $display("FAIL restart_s0: valid %b data %0d, required 1/50", data_valid, $signed(data_out[DW-1:0])); end
  endtask

  task automatic test_fw_zero();
    int bad = 0;
    set_fw(0, 0);
    mode = 2'd0;
    do_reset();
    capture(8, 50);
    for (int k = 0; k < 8; k++)
      if (int'(s0[k]) !== 50 || int'(s1[k]) !== 50 || sw[k] !== '0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fw0_sine: %0d wrong samples, required 0", bad); end
    mode = 2'd3;
    do_reset();
    capture(8, 50);
    bad = 0;
    for (int k = 0; k < 8; k++) if (int'(s0[k]) !== ((k == 0) ? 32767 : 0)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fw0_impulse: %0d wrong samples, required 0", bad); end
    mode = 2'd0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sine_basic();
    test_divider();
    test_modes();
    test_two_channel();
    test_clear_priority();
    test_enable_hold();
    test_reset_midstream();
    test_fw_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
